lane_frame_serializer: RTL

- Downstream consumer of the producer stage's `wor` output array: 5 unpacked lanes, each `logic [3:4][0:2][1:4][1:2]` (48 bits, 4-state).
- Captures one frame of lanes on a valid/ready handshake and streams it out as 16-bit 2-state words shaped `bit [2:1][0:1][4:1]`, the producer's status-word shape.
- Flags, per lane, whether the captured lane contained any x/z bit.
- Sits between the producer stage and any 2-state sink.

---
 rtl/lane_frame_pkg.sv | 21 ++
 rtl/lane_frame_serializer_if.sv | 47 ++++
 rtl/lane_xz_detect.sv | 14 +
 rtl/lane_frame_serializer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/lane_frame_pkg.sv
// Shared types and constants for the lane frame serializer.
package lane_frame_pkg;

  // One producer lane: 48 bits, 4-state. Bit 47 is element [3][0][1][1].
  typedef logic [3:4][0:2][1:4][1:2] lane_t;

  // One output beat: 16 bits, 2-state, producer status-word shape.
  typedef bit [2:1][0:1][4:1] word_t;

  localparam int unsigned LANE_W     = $bits(lane_t);
  localparam int unsigned WORD_W     = $bits(word_t);
  localparam int unsigned BEATS      = LANE_W / WORD_W;
  localparam int unsigned LANE_IDX_W = 3;
  localparam int unsigned BEAT_W     = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/lane_frame_serializer_if.sv
// Handshake and data bundle between the producer, the serializer and the 2-state sink.
interface lane_frame_serializer_if
  import lane_frame_pkg::*;
#(
  parameter int unsigned NUM_LANES = 5
);

  logic                 in_valid;
  logic                 in_ready;
  lane_t                lanes_in [NUM_LANES-1:0];
  logic                 out_valid;
  logic                 out_ready;
  word_t                out_data;
  logic [LANE_IDX_W-1:0] out_lane;
  logic [BEAT_W-1:0]    out_beat;
  logic                 out_last;
  logic [NUM_LANES-1:0] xz_lanes;

  // Producer / sink side (drives frames and out_ready).
  modport master (
    output in_valid,
    input  in_ready,
    output lanes_in,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_lane,
    input  out_beat,
    input  out_last,
    input  xz_lanes
  );

  // Serializer side.
  modport slave (
    input  in_valid,
    output in_ready,
    input  lanes_in,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_lane,
    output out_beat,
    output out_last,
    output xz_lanes
  );

endinterface

// File: rtl/lane_xz_detect.sv
// Combinational flag: 1 when any bit of the lane is x or z.
module lane_xz_detect
  import lane_frame_pkg::*;
(
  input  lane_t lane_i,
  output logic  xz_o
);

  // Reduction XOR propagates any x/z bit to an x result.
  always_comb begin
    xz_o = (^lane_i === 1'bx);
  end

endmodule

// File: rtl/lane_frame_serializer.sv
// Captures a frame of 4-state lanes and streams it as 2-state 16-bit beats,
// lane 0 first, most-significant slice of each lane first.
module lane_frame_serializer
  import lane_frame_pkg::*;
#(
  parameter int unsigned NUM_LANES = 5,
  parameter int unsigned LANE_W    = 48,
  parameter int unsigned WORD_W    = 16
) (
  input logic                    clk,
  input logic                    rst,
  lane_frame_serializer_if.slave bus
);

  localparam int unsigned NBEATS = LANE_W / WORD_W;

  if (LANE_W % WORD_W != 0) begin : g_bad_ratio
    $error("LANE_W must be a multiple of WORD_W");
  end
  if (LANE_W != $bits(lane_t)) begin : g_bad_lane_w
    $error("LANE_W must match the lane type width");
  end
  if (WORD_W != $bits(word_t)) begin : g_bad_word_w
    $error("WORD_W must match the word type width");
  end
  if (NUM_LANES < 1 || NUM_LANES > (1 << LANE_IDX_W)) begin : g_bad_lanes
    $error("NUM_LANES does not fit the lane index");
  end
  if (NBEATS < 1 || NBEATS > (1 << BEAT_W)) begin : g_bad_beats
    $error("beats per lane do not fit the beat index");
  end

  state_t                state_q, state_d;
  lane_t                 lanes_q [NUM_LANES-1:0];
  lane_t                 lanes_d [NUM_LANES-1:0];
  logic [NUM_LANES-1:0]  xz_q, xz_d, xz_now;
  logic [LANE_IDX_W-1:0] lane_q, lane_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;

  logic                  idx_ok;
  logic                  at_last_beat;
  logic                  at_last_lane;
  logic [LANE_W-1:0]     cur_flat;
  logic [LANE_W-1:0]     cur_shifted;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_xz
    lane_xz_detect u_xz (
      .lane_i (bus.lanes_in[k]),
      .xz_o   (xz_now[k])
    );
  end

  // Counter decode shared by next-state and output logic.
  always_comb begin
    idx_ok       = (32'(lane_q) < NUM_LANES) && (32'(beat_q) < NBEATS);
    at_last_beat = (32'(beat_q) == NBEATS - 1);
    at_last_lane = (32'(lane_q) == NUM_LANES - 1);
  end

  // Next-state: capture in IDLE, advance lane/beat on each accepted beat in SEND.
  always_comb begin
    state_d = state_q;
    lanes_d = lanes_q;
    xz_d    = xz_q;
    lane_d  = lane_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          lanes_d = bus.lanes_in;
          xz_d    = xz_now;
          lane_d  = '0;
          beat_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!idx_ok) begin
          // Corrupted counters: drop the frame rather than stream garbage.
          lane_d  = '0;
          beat_d  = '0;
          state_d = IDLE;
        end else if (bus.out_ready) begin
          if (at_last_beat && at_last_lane) begin
            lane_d  = '0;
            beat_d  = '0;
            state_d = IDLE;
          end else if (at_last_beat) begin
            beat_d = '0;
            lane_d = lane_q + 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: begin
        lane_d  = '0;
        beat_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      xz_q    <= '0;
      lane_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      xz_q    <= xz_d;
      lane_q  <= lane_d;
      beat_q  <= beat_d;
    end
  end

  // Frame storage; contents are irrelevant outside SEND so no reset is needed.
  always_ff @(posedge clk) begin
    lanes_q <= lanes_d;
  end

  // Outputs: select the current slice and collapse x/z to 0 via the 2-state cast.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_lane  = lane_q;
    bus.out_beat  = beat_q;
    bus.out_last  = 1'b0;
    bus.xz_lanes  = xz_q;
    cur_flat      = '0;
    cur_shifted   = '0;
    if (state_q == SEND) begin
      bus.out_valid = 1'b1;
      if (idx_ok) begin
        cur_flat     = lanes_q[lane_q];
        cur_shifted  = cur_flat >> (WORD_W * (NBEATS - 1 - 32'(beat_q)));
        bus.out_data = word_t'(cur_shifted[WORD_W-1:0]);
        bus.out_last = at_last_beat && at_last_lane;
      end
    end else begin
      bus.in_ready = 1'b1;
    end
  end

endmodule
